// File: rtl/freq_scan_ctrl.sv
// Frequency scan controller: shares one gated rising-edge counter across NUM_CH inputs,
// visiting enabled channels in ascending order (settle window, then gate window, then store).
module freq_scan_ctrl #(
    parameter int NUM_CH        = 4,
    parameter int GATE_CYCLES   = 100000000,
    parameter int SETTLE_CYCLES = 16,
    parameter int CNT_W         = 12
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [NUM_CH-1:0]        IN,
    input  logic [NUM_CH-1:0]        CH_EN,
    input  logic                     START,
    input  logic                     CONTINUOUS,
    input  logic                     ABORT,
    output logic                     BUSY,
    output logic [2:0]               CUR_CH,
    output logic                     RESULT_VALID,
    output logic [2:0]               RESULT_CH,
    output logic [CNT_W-1:0]         RESULT_FREQ,
    output logic                     RESULT_OVF,
    output logic [NUM_CH*CNT_W-1:0]  FREQ_ALL,
    output logic                     DONE,
    output logic [2:0]               STATE_DBG
);

    localparam int MAX_WIN = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int CYC_W   = $clog2(MAX_WIN) + 1;
    localparam int PTR_W   = $clog2(NUM_CH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE_CYCLES - 1);
    localparam logic [CYC_W-1:0] GATE_LAST   = CYC_W'(GATE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_SETTLE = 3'd2,
        S_GATE   = 3'd3,
        S_STORE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_CH-1:0]  sync1_q, sync1_d, sync2_q, sync2_d;
    logic               last_q, last_d;
    logic [2:0]         cur_ch_q, cur_ch_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               res_valid_q, res_valid_d;
    logic [2:0]         res_ch_q, res_ch_d;
    logic [CNT_W-1:0]   res_freq_q, res_freq_d;
    logic               res_ovf_q, res_ovf_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   freq_all_q [NUM_CH];
    logic [CNT_W-1:0]   freq_all_d [NUM_CH];

    logic               sel_bit;
    logic               rise;
    logic               found;
    logic [2:0]         found_ch;

    always_comb begin
        sel_bit = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cur_ch_q == 3'(i)) sel_bit = sync2_q[i];
        end
        rise = sel_bit & ~last_q;

        // Descending scan so the last hit is the lowest enabled channel at or above ptr_q.
        found    = 1'b0;
        found_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (CH_EN[i] && (PTR_W'(i) >= ptr_q)) begin
                found    = 1'b1;
                found_ch = 3'(i);
            end
        end

        state_d     = state_q;
        sync1_d     = IN;
        sync2_d     = sync1_q;
        last_d      = sel_bit;
        cur_ch_d    = cur_ch_q;
        ptr_d       = ptr_q;
        cyc_d       = cyc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        res_valid_d = 1'b0;
        res_ch_d    = res_ch_q;
        res_freq_d  = res_freq_q;
        res_ovf_d   = res_ovf_q;
        done_d      = 1'b0;
        for (int k = 0; k < NUM_CH; k++) freq_all_d[k] = freq_all_q[k];

        if (ABORT) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        state_d = S_SELECT;
                        ptr_d   = '0;
                    end
                end
                S_SELECT: begin
                    if (found) begin
                        cur_ch_d = found_ch;
                        cyc_d    = '0;
                        cnt_d    = '0;
                        ovf_d    = 1'b0;
                        state_d  = S_SETTLE;
                    end else if (CONTINUOUS && (|CH_EN)) begin
                        ptr_d = '0;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_SETTLE: begin
                    if (cyc_q == SETTLE_LAST) begin
                        cyc_d   = '0;
                        state_d = S_GATE;
                    end else begin
                        cyc_d = cyc_q + CYC_W'(1);
                    end
                end
                S_GATE: begin
                    if (rise) begin
                        if (cnt_q == CNT_MAX) ovf_d = 1'b1;
                        else                  cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (cyc_q == GATE_LAST) state_d = S_STORE;
                    else                    cyc_d   = cyc_q + CYC_W'(1);
                end
                S_STORE: begin
                    res_valid_d = 1'b1;
                    res_ch_d    = cur_ch_q;
                    res_freq_d  = cnt_q;
                    res_ovf_d   = ovf_q;
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (cur_ch_q == 3'(k)) freq_all_d[k] = cnt_q;
                    end
                    ptr_d   = PTR_W'(cur_ch_q) + PTR_W'(1);
                    state_d = S_SELECT;
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            sync1_q     <= '0;
            sync2_q     <= '0;
            last_q      <= 1'b0;
            cur_ch_q    <= '0;
            ptr_q       <= '0;
            cyc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_ch_q    <= '0;
            res_freq_q  <= '0;
            res_ovf_q   <= 1'b0;
            done_q      <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) freq_all_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            last_q      <= last_d;
            cur_ch_q    <= cur_ch_d;
            ptr_q       <= ptr_d;
            cyc_q       <= cyc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
            res_ch_q    <= res_ch_d;
            res_freq_q  <= res_freq_d;
            res_ovf_q   <= res_ovf_d;
            done_q      <= done_d;
            for (int k = 0; k < NUM_CH; k++) freq_all_q[k] <= freq_all_d[k];
        end
    end

    always_comb begin
        FREQ_ALL = '0;
        for (int k = 0; k < NUM_CH; k++) FREQ_ALL[k*CNT_W +: CNT_W] = freq_all_q[k];
    end

    assign BUSY         = busy_q;
    assign CUR_CH       = cur_ch_q;
    assign RESULT_VALID = res_valid_q;
    assign RESULT_CH    = res_ch_q;
    assign RESULT_FREQ  = res_freq_q;
    assign RESULT_OVF   = res_ovf_q;
    assign DONE         = done_q;
    assign STATE_DBG    = state_q;

endmodule

// File: tb/tb_freq_scan_ctrl.sv
// Bench for freq_scan_ctrl: table of single scans plus directed sequences for continuous
// scanning, saturation, abort, async reset and the constant-input / empty-mask corners.
module tb_freq_scan_ctrl;

    localparam int NCH  = 4;
    localparam int GATE = 1000;
    localparam int SETL = 4;

    logic        clk, rst_n;
    logic [3:0]  in_bus, ch_en;
    logic        start, continuous, abort;

    logic        busy, result_valid, result_ovf, done;
    logic [2:0]  cur_ch, result_ch, state_dbg;
    logic [11:0] result_freq;
    logic [47:0] freq_all;

    logic        busy_4, result_valid_4, result_ovf_4, done_4;
    logic [2:0]  cur_ch_4, result_ch_4, state_dbg_4;
    logic [3:0]  result_freq_4;
    logic [15:0] freq_all_4;

    freq_scan_ctrl #(.NUM_CH(NCH), .GATE_CYCLES(GATE), .SETTLE_CYCLES(SETL), .CNT_W(12)) u_dut (
        .CLK(clk), .RST_N(rst_n), .IN(in_bus), .CH_EN(ch_en), .START(start),
        .CONTINUOUS(continuous), .ABORT(abort), .BUSY(busy), .CUR_CH(cur_ch),
        .RESULT_VALID(result_valid), .RESULT_CH(result_ch), .RESULT_FREQ(result_freq),
        .RESULT_OVF(result_ovf), .FREQ_ALL(freq_all), .DONE(done), .STATE_DBG(state_dbg)
    );

    freq_scan_ctrl #(.NUM_CH(NCH), .GATE_CYCLES(GATE), .SETTLE_CYCLES(SETL), .CNT_W(4)) u_dut4 (
        .CLK(clk), .RST_N(rst_n), .IN(in_bus), .CH_EN(ch_en), .START(start),
        .CONTINUOUS(continuous), .ABORT(abort), .BUSY(busy_4), .CUR_CH(cur_ch_4),
        .RESULT_VALID(result_valid_4), .RESULT_CH(result_ch_4), .RESULT_FREQ(result_freq_4),
        .RESULT_OVF(result_ovf_4), .FREQ_ALL(freq_all_4), .DONE(done_4), .STATE_DBG(state_dbg_4)
    );

    // ---------------- clock / input generation ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int per [4];
    int ph  [4];
    bit lvl [4];

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (per[i] == 0) begin
                in_bus[i] = lvl[i];
            end else begin
                ph[i]     = (ph[i] + 1) % per[i];
                in_bus[i] = (ph[i] < per[i] / 2);
            end
        end
    end

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [2:0]  exp_ch_q   [$];
    logic [11:0] exp_freq_q [$];
    int          freq_model [4];

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_tol(input string name, input longint act, input longint exp);
        n_checks++;
        if ((act > exp + 1) || (act < exp - 1)) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d +/-1 (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_freq_all();
        for (int k = 0; k < 4; k++) chk_tol($sformatf("freq_all_ch%0d", k), freq_all[k*12 +: 12], freq_model[k]);
    endtask

    // Pulses START, then collects results against the expected queues until DONE or budget.
    // Called #1 after a rising edge. drop_after>0 clears CONTINUOUS after that many results.
    task automatic run_scan(input logic [3:0] en, input bit cont, input int drop_after, input int budget);
        int cyc, seen, last_v, nexp;
        bit done_seen;
        logic [2:0]  ech;
        logic [11:0] ef;
        nexp = exp_ch_q.size();
        ch_en = en;
        continuous = cont;
        start = 1'b1;
        cyc = 0; seen = 0; last_v = -100; done_seen = 0;
        while (!done_seen && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            if (result_valid) begin
                seen++;
                last_v = cyc;
                chk("valid_done_overlap", done, 0);
                if (exp_ch_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got ch %0d freq %0d expected none", result_ch, result_freq);
                end else begin
                    ech = exp_ch_q.pop_front();
                    ef  = exp_freq_q.pop_front();
                    chk("result_ch", result_ch, ech);
                    chk_tol("result_freq", result_freq, ef);
                    chk("result_ovf", result_ovf, 0);
                    chk("dut4_valid", result_valid_4, 1);
                    chk("dut4_freq", result_freq_4, (ef > 15) ? 15 : ef);
                    chk("dut4_ovf", result_ovf_4, (ef > 15) ? 1 : 0);
                    freq_model[ech] = ef;
                end
                if (seen == drop_after) continuous = 1'b0;
            end
            if (done) done_seen = 1;
        end
        chk("done_seen", done_seen, 1);
        chk("results_missing", exp_ch_q.size(), 0);
        exp_ch_q.delete();
        exp_freq_q.delete();
        if (done_seen) begin
            if (nexp > 0) chk("done_latency", cyc, last_v + 1);
            else          chk("done_latency_empty", cyc, 2);
            chk("busy_at_done", busy, 0);
        end
        check_freq_all();
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [3:0]       ch_en;
        logic [2:0]       n;
        logic [3:0][2:0]  ch;    // element 0 is the rightmost field
        logic [3:0][11:0] freq;
    } scan_vec_t;

    scan_vec_t vecs [4];

    initial begin
        per = '{10, 4, 20, 50};
        ph  = '{0, 1, 5, 17};
        lvl = '{0, 0, 0, 0};
        in_bus = '0;
        ch_en = '0; start = 0; continuous = 0; abort = 0;
        for (int k = 0; k < 4; k++) freq_model[k] = 0;
        rst_n = 1'b0;

        vecs[0] = '{ch_en: 4'b0001, n: 3'd1, ch: {3'd0, 3'd0, 3'd0, 3'd0}, freq: {12'd0, 12'd0, 12'd0, 12'd100}};
        vecs[1] = '{ch_en: 4'b1101, n: 3'd3, ch: {3'd0, 3'd3, 3'd2, 3'd0}, freq: {12'd0, 12'd20, 12'd50, 12'd100}};
        vecs[2] = '{ch_en: 4'b0010, n: 3'd1, ch: {3'd0, 3'd0, 3'd0, 3'd1}, freq: {12'd0, 12'd0, 12'd0, 12'd250}};
        vecs[3] = '{ch_en: 4'b0000, n: 3'd0, ch: {3'd0, 3'd0, 3'd0, 3'd0}, freq: {12'd0, 12'd0, 12'd0, 12'd0}};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_cur_ch", cur_ch, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_freq", result_freq, 0);
        chk("rst_freq_all", freq_all, 0);
        chk("rst_done", done, 0);
        chk("rst_state", state_dbg, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < int'(vecs[v].n); i++) begin
                exp_ch_q.push_back(vecs[v].ch[i]);
                exp_freq_q.push_back(vecs[v].freq[i]);
            end
            run_scan(vecs[v].ch_en, 1'b0, -1, 3500);
            repeat (2) @(posedge clk);
            #1;
        end

        // continuous over ch0/ch2; CONTINUOUS drops after the 7th result so the 8th (ch2) ends it
        for (int p = 0; p < 4; p++) begin
            exp_ch_q.push_back(3'd0); exp_freq_q.push_back(12'd100);
            exp_ch_q.push_back(3'd2); exp_freq_q.push_back(12'd50);
        end
        run_scan(4'b0101, 1'b1, 7, 9000);
        @(posedge clk); #1;

        // constant-high input: switching the mux onto it must not look like an edge
        per[0] = 0; lvl[0] = 1;
        repeat (5) @(posedge clk);
        #1;
        exp_ch_q.push_back(3'd0); exp_freq_q.push_back(12'd0);
        run_scan(4'b0001, 1'b0, -1, 1500);
        per[0] = 10;

        // ABORT together with START in IDLE keeps IDLE
        start = 1; abort = 1; ch_en = 4'b0001;
        @(posedge clk); #1;
        start = 0; abort = 0;
        chk("abort_start_idle_busy", busy, 0);
        chk("abort_start_idle_state", state_dbg, 0);

        // ABORT at gate cycle 500
        begin
            int nv, nd;
            start = 1;
            @(posedge clk); #1;
            start = 0;
            repeat (SETL + 499) @(posedge clk);
            #1;
            chk("pre_abort_in_gate", state_dbg, 3);
            abort = 1;
            @(posedge clk); #1;
            abort = 0;
            chk("abort_busy", busy, 0);
            chk("abort_state", state_dbg, 0);
            nv = 0; nd = 0;
            for (int c = 0; c < 1100; c++) begin
                @(posedge clk); #1;
                if (result_valid) nv++;
                if (done) nd++;
            end
            chk("abort_no_valid", nv, 0);
            chk("abort_no_done", nd, 0);
            chk("abort_result_ch_kept", result_ch, 0);
            check_freq_all();
        end

        // async reset in the middle of a ch3 gate
        ch_en = 4'b1000; start = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (300) @(posedge clk);
        #1;
        chk("pre_reset_cur_ch", cur_ch, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_cur_ch", cur_ch, 0);
        chk("arst_result_ch", result_ch, 0);
        chk("arst_result_freq", result_freq, 0);
        chk("arst_result_ovf", result_ovf, 0);
        chk("arst_freq_all", freq_all, 0);
        chk("arst_freq_all_4", freq_all_4, 0);
        chk("arst_state", state_dbg, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post_reset_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
